// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution, redirect shadow guard and branch statistics
module branch_resolve #(
  parameter int XLEN = 32,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic [1:0]      BranchTypeD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic            ZeroE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic [2:0]      ALUControlE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [CW-1:0]   BrCount,
  output logic [CW-1:0]   TakenCount
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SHADOW = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_branch_e;
  logic            r_jump_e;
  logic [1:0]      r_branch_type_e;
  logic [2:0]      r_alu_control_e;
  logic [XLEN-1:0] r_pc_e;
  logic [XLEN-1:0] r_imm_ext_e;
  logic [CW-1:0]   r_br_count;
  logic [CW-1:0]   r_taken_count;

  logic            w_cond_e;
  logic            w_pcsrc_e;
  logic            w_unused_alu_result;

  // Only the slt outcome in bit 0 feeds the condition.
  assign w_unused_alu_result = ^ALUResultE[XLEN-1:1];

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_branch_e      <= 1'b0;
      r_jump_e        <= 1'b0;
      r_branch_type_e <= 2'b00;
      r_alu_control_e <= 3'b000;
      r_pc_e          <= '0;
      r_imm_ext_e     <= '0;
    end else if (!StallE) begin
      r_branch_e      <= BranchD;
      r_jump_e        <= JumpD;
      r_branch_type_e <= BranchTypeD;
      r_alu_control_e <= ALUControlD;
      r_pc_e          <= PCD;
      r_imm_ext_e     <= ImmExtD;
    end
  end

  always_comb begin
    w_cond_e = 1'b0;
    unique case (r_branch_type_e)
      2'b00: w_cond_e = ZeroE;
      2'b01: w_cond_e = !ZeroE;
      2'b10: w_cond_e = ALUResultE[0];
      2'b11: w_cond_e = !ALUResultE[0];
    endcase
  end

  // A jump dominates, so the illegal branch+jump encoding resolves as a taken jump.
  assign w_pcsrc_e = (r_jump_e | (r_branch_e & w_cond_e)) & (r_state != S_SHADOW);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!StallE && (r_branch_e || r_jump_e)) begin
            r_br_count <= r_br_count + CW'(1);
            if (w_pcsrc_e) begin
              r_taken_count <= r_taken_count + CW'(1);
            end
          end
          if (w_pcsrc_e && !StallE) begin
            r_state <= S_SHADOW;
          end
        end
        // The shadow lasts exactly one cycle even under stall.
        S_SHADOW: r_state <= S_IDLE;
      endcase
    end
  end

  assign ALUControlE = r_alu_control_e;
  assign PCSrcE      = w_pcsrc_e;
  assign PCTargetE   = r_pc_e + r_imm_ext_e;
  assign BrCount     = r_br_count;
  assign TakenCount  = r_taken_count;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed and randomized bench for branch_resolve
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset, StallE, FlushE, BranchD, JumpD, ZeroE;
  logic [1:0]  BranchTypeD;
  logic [2:0]  ALUControlD;
  logic [31:0] PCD, ImmExtD, ALUResultE;
  logic [2:0]  ALUControlE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [15:0] BrCount, TakenCount;

  int checks = 0;
  int errors = 0;

  // Reference model of the E-stage contents and the statistics.
  bit          m_br, m_jmp, m_shadow;
  logic [1:0]  m_bt;
  logic [2:0]  m_aluc;
  logic [31:0] m_pc, m_imm;
  logic [15:0] m_brc, m_tkc;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .CW(16)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .BranchD(BranchD), .JumpD(JumpD), .BranchTypeD(BranchTypeD),
    .ALUControlD(ALUControlD), .PCD(PCD), .ImmExtD(ImmExtD),
    .ZeroE(ZeroE), .ALUResultE(ALUResultE), .ALUControlE(ALUControlE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BrCount(BrCount),
    .TakenCount(TakenCount)
  );

  function automatic bit branch_taken();
    bit lt;
    lt = ALUResultE[0];
    case (m_bt)
      2'b00:   return ZeroE;
      2'b01:   return !ZeroE;
      2'b10:   return lt;
      default: return !lt;
    endcase
  endfunction

  function automatic bit exp_pcsrc();
    if (m_shadow) return 1'b0;
    return m_jmp || (m_br && branch_taken());
  endfunction

  function automatic logic [31:0] exp_target();
    return m_pc + m_imm;
  endfunction

  task automatic clear_e_model();
    m_br = 0; m_jmp = 0; m_bt = 0; m_aluc = 0; m_pc = 0; m_imm = 0;
  endtask

  task automatic tick();
    bit taken;
    taken = exp_pcsrc();
    if (reset) begin
      clear_e_model();
      m_shadow = 0; m_brc = 0; m_tkc = 0;
    end else begin
      if (!StallE && !m_shadow && (m_br || m_jmp)) begin
        m_brc = m_brc + 16'd1;
        if (taken) m_tkc = m_tkc + 16'd1;
      end
      m_shadow = m_shadow ? 1'b0 : (taken && !StallE);
      if (FlushE) clear_e_model();
      else if (!StallE) begin
        m_br = BranchD; m_jmp = JumpD; m_bt = BranchTypeD;
        m_aluc = ALUControlD; m_pc = PCD; m_imm = ImmExtD;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    BranchD = 0; JumpD = 0; BranchTypeD = 0; ALUControlD = 0; PCD = 0; ImmExtD = 0;
  endtask

  task automatic test_reset();
    reset = 1; StallE = 0; FlushE = 0; ZeroE = 0; ALUResultE = 0;
    clear_d();
    ALUControlD = 3'd6; PCD = 32'h44; JumpD = 1;
    tick();
    tick();
    checks++; if (ALUControlE !== 3'd0) begin errors++; $display("FAIL reset_aluc got %h exp 0", ALUControlE); end
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got %b exp 0", PCSrcE); end
    checks++; if (PCTargetE !== 32'd0) begin errors++; $display("FAIL reset_target got %h exp 0", PCTargetE); end
    checks++; if (BrCount !== 16'd0 || TakenCount !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %h/%h exp 0/0", BrCount, TakenCount); end
    reset = 0;
    clear_d();
    tick();
  endtask

  task automatic test_beq_taken();
    BranchD = 1; BranchTypeD = 2'b00; PCD = 32'h100; ImmExtD = 32'h20; ALUControlD = 3'd1;
    ZeroE = 0;
    tick();
    clear_d();
    ZeroE = 1;
    #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL beq_pcsrc got %b exp 1", PCSrcE); end
    checks++; if (PCTargetE !== 32'h120) begin errors++; $display("FAIL beq_target got %h exp 120", PCTargetE); end
    checks++; if (ALUControlE !== 3'd1) begin errors++; $display("FAIL beq_aluc got %h exp 1", ALUControlE); end
    tick();
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_shadow got %b exp 0", PCSrcE); end
    checks++; if (BrCount !== 16'd1 || TakenCount !== 16'd1) begin
      errors++; $display("FAIL beq_counts got %h/%h exp 1/1", BrCount, TakenCount); end
    tick();
  endtask

  task automatic test_cond_sweep();
    logic [1:0]  types [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    bit          exp   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] b0, t0;
    b0 = m_brc; t0 = m_tkc;
    ZeroE = 0; ALUResultE = 0;
    for (int i = 0; i < 4; i++) begin
      BranchD = 1; BranchTypeD = types[i]; PCD = $urandom; ImmExtD = $urandom;
      tick();
      clear_d();
      #1;
      checks++; if (PCSrcE !== exp[i]) begin
        errors++; $display("FAIL sweep_type%0d got %b exp %b", types[i], PCSrcE, exp[i]); end
      tick();
      tick();
    end
    checks++; if (BrCount !== b0 + 16'd4 || TakenCount !== t0 + 16'd2) begin
      errors++; $display("FAIL sweep_counts got %h/%h exp %h/%h", BrCount, TakenCount, b0 + 16'd4, t0 + 16'd2); end
  endtask

  task automatic test_stall_hold();
    logic [15:0] b0, t0;
    b0 = m_brc; t0 = m_tkc;
    JumpD = 1; PCD = 32'h200; ImmExtD = 32'h40;
    tick();
    clear_d();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (PCSrcE !== 1'b1 || BrCount !== b0 || TakenCount !== t0) begin
        errors++; $display("FAIL stall_hold%0d got %b %h/%h exp 1 %h/%h", i, PCSrcE, BrCount, TakenCount, b0, t0); end
      tick();
    end
    StallE = 0;
    #1;
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h240) begin
      errors++; $display("FAIL stall_release got %b %h exp 1 240", PCSrcE, PCTargetE); end
    tick();
    checks++; if (PCSrcE !== 1'b0 || BrCount !== b0 + 16'd1 || TakenCount !== t0 + 16'd1) begin
      errors++; $display("FAIL stall_after got %b %h/%h exp 0 %h/%h", PCSrcE, BrCount, TakenCount, b0 + 16'd1, t0 + 16'd1); end
    tick();
  endtask

  task automatic test_flush_priority();
    ZeroE = 0;
    BranchD = 1; BranchTypeD = 2'b00; ALUControlD = 3'd5; PCD = 32'h300; ImmExtD = 32'h4;
    tick();
    BranchD = 1; BranchTypeD = 2'b01; ALUControlD = 3'd7; PCD = 32'h380; ImmExtD = 32'h8;
    FlushE = 1; StallE = 1;
    tick();
    FlushE = 0; StallE = 0;
    clear_d();
    #1;
    checks++; if (ALUControlE !== 3'd0 || PCTargetE !== 32'd0 || PCSrcE !== 1'b0) begin
      errors++; $display("FAIL flush_priority got %h %h %b exp 0 0 0", ALUControlE, PCTargetE, PCSrcE); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] b0, t0;
    b0 = m_brc; t0 = m_tkc;
    ZeroE = 1;
    BranchD = 1; BranchTypeD = 2'b00; PCD = 32'h400; ImmExtD = 32'h10;
    tick();
    clear_d();
    JumpD = 1; PCD = 32'h500; ImmExtD = 32'h8;
    #1;
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h410) begin
      errors++; $display("FAIL b2b_branch got %b %h exp 1 410", PCSrcE, PCTargetE); end
    tick();
    clear_d();
    #1;
    checks++; if (PCSrcE !== 1'b0 || PCTargetE !== 32'h508) begin
      errors++; $display("FAIL b2b_jump_suppressed got %b %h exp 0 508", PCSrcE, PCTargetE); end
    tick();
    checks++; if (BrCount !== b0 + 16'd1 || TakenCount !== t0 + 16'd1) begin
      errors++; $display("FAIL b2b_counts got %h/%h exp %h/%h", BrCount, TakenCount, b0 + 16'd1, t0 + 16'd1); end
    ZeroE = 0;
  endtask

  task automatic test_wrap_and_reset();
    int guard;
    PCD = 32'hFFFF_FFF0; ImmExtD = 32'h20;
    tick();
    clear_d();
    #1;
    checks++; if (PCTargetE !== 32'h0000_0010) begin
      errors++; $display("FAIL target_wrap got %h exp 00000010", PCTargetE); end
    JumpD = 1; PCD = 32'h600; ImmExtD = 32'h4; ALUControlD = 3'd2;
    tick();
    ALUControlD = 3'd3;
    tick();
    reset = 1;
    tick();
    reset = 0;
    clear_d();
    checks++; if (ALUControlE !== 3'd0 || PCSrcE !== 1'b0 || PCTargetE !== 32'd0 ||
                  BrCount !== 16'd0 || TakenCount !== 16'd0) begin
      errors++; $display("FAIL reset_in_shadow got %h %b %h %h/%h exp all 0",
                         ALUControlE, PCSrcE, PCTargetE, BrCount, TakenCount); end
    // Back-to-back not-taken branches count once per cycle without opening a shadow.
    BranchD = 1; BranchTypeD = 2'b00; ZeroE = 0;
    guard = 0;
    while (m_brc != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    checks++; if (BrCount !== 16'hFFFF) begin
      errors++; $display("FAIL count_max got %h exp ffff", BrCount); end
    tick();
    checks++; if (BrCount !== 16'h0000 || TakenCount !== 16'h0000) begin
      errors++; $display("FAIL count_wrap got %h/%h exp 0000/0000", BrCount, TakenCount); end
    clear_d();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      StallE      = ($urandom_range(0, 3) == 0);
      FlushE      = ($urandom_range(0, 7) == 0);
      BranchD     = $urandom_range(0, 1);
      JumpD       = ($urandom_range(0, 4) == 0);
      BranchTypeD = 2'($urandom);
      ALUControlD = 3'($urandom);
      PCD         = $urandom;
      ImmExtD     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
      ZeroE       = $urandom_range(0, 1);
      ALUResultE  = $urandom;
      #1;
      checks++; if (PCSrcE !== exp_pcsrc() || PCTargetE !== exp_target() || ALUControlE !== m_aluc ||
                    BrCount !== m_brc || TakenCount !== m_tkc) begin
        errors++; $display("FAIL random_%0d got %b %h %h %h/%h exp %b %h %h %h/%h", i,
                           PCSrcE, PCTargetE, ALUControlE, BrCount, TakenCount,
                           exp_pcsrc(), exp_target(), m_aluc, m_brc, m_tkc); end
      tick();
    end
    reset = 0; StallE = 0; FlushE = 0;
  endtask

  initial begin
    clear_e_model();
    m_shadow = 0; m_brc = 0; m_tkc = 0;
    test_reset();
    test_beq_taken();
    test_cond_sweep();
    test_stall_hold();
    test_flush_priority();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the pipelined RISC-V core, sitting downstream of the ALU decoder and consuming its ALUControl/BranchType outputs. It holds the ID/EX copy of the branch/jump control fields, evaluates the branch condition from the ALU's Zero flag and result, and drives the PC redirect and target. It also guards the redirect shadow cycle and keeps resolved-branch and taken-branch statistics counters.

## Interface
- `XLEN`, 32: PC and immediate width.
- `CW`, 16: statistics counter width.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `StallE` input 1: hold the E-stage register from the hazard unit.
- `FlushE` input 1: bubble the E-stage register from the hazard unit. Has priority over `StallE`.
- `BranchD` input 1: D-stage conditional branch.
- `JumpD` input 1: D-stage jal.
- `BranchTypeD` input 2: condition select. 00 beq, 01 bne, 10 blt, 11 bge.
- `ALUControlD` input 3: ALU operation. Registered and forwarded only.
- `PCD` input XLEN: D-stage PC.
- `ImmExtD` input XLEN: D-stage sign-extended immediate.
- `ZeroE` input 1: ALU zero flag for the E-stage instruction.
- `ALUResultE` input XLEN: ALU result. Bit 0 is the slt outcome.
- `ALUControlE` output 3: registered ALU operation to the ALU.
- `PCSrcE` output 1: redirect PC to `PCTargetE`.
- `PCTargetE` output XLEN: branch/jump target.
- `BrCount` output CW: resolved branches plus jumps.
- `TakenCount` output CW: taken branches plus jumps.

## Operation
- E-stage register contents: `BranchE`, `JumpE`, `BranchTypeE`, `ALUControlE`, `PCE`, `ImmExtE`.
- E-stage register update on each posedge, in priority order:
  - `reset` or `FlushE`: clear all fields to 0.
  - `StallE`: hold.
  - Otherwise: load the D values.
- Condition `CondE`, selected by `BranchTypeE`:
  - 00: `ZeroE`.
  - 01: `!ZeroE`.
  - 10: `ALUResultE[0]`.
  - 11: `!ALUResultE[0]`.
- `PCSrcE` (combinational) = (`JumpE` | (`BranchE` & `CondE`)) & (state != SHADOW).
- `PCTargetE` = `PCE` + `ImmExtE`, mod 2^XLEN. Wrap-around is silent.
- State machine, two states:
  - IDLE: if `PCSrcE` & `!StallE`, go to SHADOW. Otherwise stay.
  - SHADOW: `PCSrcE` is forced to 0 for this cycle. Unconditionally return to IDLE next cycle, even if `StallE` is high.
  - `reset` forces IDLE.
- A taken branch held by `StallE` stays in IDLE with `PCSrcE` asserted continuously until the stall releases.
- Counters, on posedge when `!reset` & `!StallE` & state == IDLE & (`BranchE` | `JumpE`):
  - `BrCount` += 1.
  - `TakenCount` += 1 if `PCSrcE`.
  - Both wrap at 2^CW.
  - Never counted: instructions in the SHADOW cycle, and stalled cycles.
- Both `BranchE` and `JumpE` set (illegal encoding): treated as jump, taken. Counted once.

## Timing
- Reset values:
  - `ALUControlE` = 0, `PCSrcE` = 0, `PCTargetE` = 0.
  - `BrCount` = 0, `TakenCount` = 0.
  - State = IDLE.
- Latency: D fields appear at the E outputs one cycle after capture.
- `PCSrcE` and `PCTargetE` are combinational from the E register and the ALU flags within the same cycle. No added register stage.
- `FlushE` and `StallE` high together: flush wins.
- Reset mid-shadow: the next state is IDLE and the counters clear; the reset cycle itself is not counted.
- Expected hazard-unit behaviour: it asserts `FlushE` in the cycle `PCSrcE` is high. SHADOW independently suppresses any branch that reaches E in the following cycle, so a single redirect per taken branch is guaranteed.

## Test plan
1. beq taken:
   - Stimulus: `BranchD`=1, `BranchTypeD`=00, `PCD`=0x100, `ImmExtD`=0x20; next cycle `ZeroE`=1.
   - Response: `PCSrcE`=1, `PCTargetE`=0x120. Next cycle: SHADOW, `PCSrcE`=0. `BrCount`=1, `TakenCount`=1.
2. Condition sweep, with `ZeroE`/`ALUResultE[0]` = (0,0):
   - bne: `PCSrcE`=1.
   - blt: `PCSrcE`=0.
   - bge: `PCSrcE`=1.
   - beq: `PCSrcE`=0.
   - After four branches, `BrCount` increases by 4 and `TakenCount` by 2 (sequence spaced to avoid SHADOW).
3. Stall hold:
   - Stimulus: taken jal in E with `StallE`=1 for 3 cycles.
   - Response: `PCSrcE`=1 for all 3 cycles; counters unchanged. On release, counters +1 and state goes to SHADOW.
4. Flush priority:
   - Stimulus: `FlushE`=1 and `StallE`=1 while `BranchD`=1.
   - Response: next cycle the E register is 0 and `PCSrcE`=0.
5. Back-to-back:
   - Stimulus: taken branch followed immediately by a taken jump in E.
   - Response: the jump is suppressed by SHADOW (`PCSrcE`=0) and not counted.
6. Wrap and reset:
   - `PCD`=0xFFFFFFF0, `ImmExtD`=0x20 -> `PCTargetE`=0x00000010.
   - Reset asserted in SHADOW -> all outputs 0 next cycle.
   - `BrCount` at 0xFFFF plus one branch -> 0x0000.
